// File: rtl/uart_rx_vote_sampler.sv
// Oversampling bit sampler for the UART receiver: majority vote over 1, 3 or 5
// samples centred on the bit midpoint, with noise and window-fit flags.
module uart_rx_vote_sampler #(
   parameter int CNT_W     = 6,
   parameter int MAX_VOTES = 5
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             S_Data,
   input  logic             S_EN,
   input  logic [CNT_W-1:0] Prescale,
   input  logic [CNT_W-1:0] edge_count,
   input  logic [1:0]       Vote_Mode,
   output logic             sampled,
   output logic             Sampled_bit,
   output logic             Noise_err,
   output logic             Cfg_err
);

   localparam int         N_W     = $clog2(MAX_VOTES + 1);
   localparam int         W       = CNT_W + 1;
   localparam logic [1:0] H_LIMIT = 2'((MAX_VOTES - 1) / 2);

   logic [1:0]           mode_q;
   logic [MAX_VOTES-1:0] samp_q;
   logic [N_W-1:0]       ones_q;
   logic [N_W-1:0]       n_q;

   logic [1:0]           h_req;
   logic [1:0]           h_use;
   logic [W-1:0]         c_ext;
   logic [W-1:0]         p_ext;
   logic [W-1:0]         p_last;
   logic [W-1:0]         ec_ext;
   logic [W-1:0]         win_lo;
   logic [W-1:0]         win_hi;
   logic [W-1:0]         dec_edge;
   logic                 in_win;
   logic                 at_start;
   logic                 at_dec;
   logic                 cfg_next;
   logic [MAX_VOTES-1:0] n_mask;
   logic [MAX_VOTES-1:0] win_bits;

   // Window geometry is computed one bit wider than the counters so C+H+1 cannot wrap.
   always_comb begin
      case (mode_q)
         2'b00:   h_req = 2'd0;
         2'b10:   h_req = 2'd2;
         default: h_req = 2'd1;
      endcase
      if (h_req > H_LIMIT) h_req = H_LIMIT;

      c_ext  = {2'b00, Prescale[CNT_W-1:1]};
      p_ext  = {1'b0, Prescale};
      p_last = p_ext - W'(1);
      ec_ext = {1'b0, edge_count};

      if (h_req >= 2'd2 && (c_ext + W'(3)) <= p_last)
         h_use = 2'd2;
      else if (h_req >= 2'd1 && (c_ext + W'(2)) <= p_last)
         h_use = 2'd1;
      else
         h_use = 2'd0;

      win_lo   = c_ext - W'(h_use);
      win_hi   = c_ext + W'(h_use);
      dec_edge = win_hi + W'(1);
      cfg_next = (h_use < h_req);

      in_win   = (ec_ext >= win_lo) && (ec_ext <= win_hi) && (ec_ext < p_ext);
      at_start = (ec_ext == win_lo);
      at_dec   = (ec_ext == dec_edge) && (ec_ext < p_ext);

      n_mask = '0;
      for (int i = 0; i < MAX_VOTES; i++) begin
         if (N_W'(i) < n_q) n_mask[i] = 1'b1;
      end
      win_bits = samp_q & n_mask;
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         sampled     <= 1'b0;
         Sampled_bit <= 1'b0;
         Noise_err   <= 1'b0;
         Cfg_err     <= 1'b0;
         mode_q      <= 2'b01;
         samp_q      <= '0;
         ones_q      <= '0;
         n_q         <= '0;
      end else begin
         Cfg_err <= cfg_next;
         sampled <= 1'b0;
         if (!S_EN) begin
            Sampled_bit <= 1'b0;
            Noise_err   <= 1'b0;
            mode_q      <= 2'b01;
            samp_q      <= '0;
            ones_q      <= '0;
            n_q         <= '0;
         end else begin
            if (edge_count == '0) mode_q <= Vote_Mode;
            if (in_win) begin
               if (at_start) begin
                  samp_q <= MAX_VOTES'(S_Data);
                  ones_q <= N_W'(S_Data);
                  n_q    <= N_W'(1);
               end else begin
                  samp_q <= (samp_q << 1) | MAX_VOTES'(S_Data);
                  ones_q <= ones_q + N_W'(S_Data);
                  n_q    <= n_q + N_W'(1);
               end
            end else if (at_dec) begin
               sampled <= 1'b1;
               if (n_q == '0) begin
                  Sampled_bit <= 1'b0;
                  Noise_err   <= 1'b1;
               end else begin
                  Sampled_bit <= (ones_q > (n_q >> 1));
                  Noise_err   <= (win_bits != '0) && (win_bits != n_mask);
               end
               // Cleared here too so a bit whose window start is skipped votes on fresh counts.
               ones_q <= '0;
               n_q    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Directed bench for uart_rx_vote_sampler: table of single-bit vectors plus
// hand-written reset/enable abort, mode-switch and disabled-config sequences.
module tb_uart_rx_vote_sampler;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       S_Data;
   logic       S_EN;
   logic [5:0] Prescale;
   logic [5:0] edge_count;
   logic [1:0] Vote_Mode;
   logic       sampled;
   logic       Sampled_bit;
   logic       Noise_err;
   logic       Cfg_err;

   int tests = 0;
   int fails = 0;

   int n_pulse;
   int pulse_pos;
   int got_bit;
   int got_noise;
   int got_cfg;

   typedef struct {
      int          p;
      logic [1:0]  mode;
      logic [63:0] data;
      logic [63:0] skip;
      int          exp_pos;
      int          exp_bit;
      int          exp_noise;
      int          exp_cfg;
   } vec_t;

   vec_t vecs[13];

   uart_rx_vote_sampler #(.CNT_W(6), .MAX_VOTES(5)) dut (
      .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .S_EN(S_EN),
      .Prescale(Prescale), .edge_count(edge_count), .Vote_Mode(Vote_Mode),
      .sampled(sampled), .Sampled_bit(Sampled_bit), .Noise_err(Noise_err),
      .Cfg_err(Cfg_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One bit period: edges 0..p-1, skipping those marked, sampling #1 after each posedge.
   task automatic run_bit(input int p, input logic [1:0] m0, input int sw, input logic [1:0] m1,
                          input logic [63:0] data, input logic [63:0] skip);
      n_pulse   = 0;
      pulse_pos = -1;
      S_EN      = 1'b1;
      Prescale  = 6'(p);
      Vote_Mode = m0;
      for (int k = 0; k < p; k++) begin
         if (k == sw) Vote_Mode = m1;
         if (!skip[k]) begin
            edge_count = 6'(k);
            S_Data     = data[k];
            @(posedge CLK); #1;
            if (sampled) begin
               n_pulse++;
               pulse_pos = k;
               got_bit   = int'(Sampled_bit);
               got_noise = int'(Noise_err);
               got_cfg   = int'(Cfg_err);
            end
         end
      end
   endtask

   task automatic abort_bit(input bit use_reset);
      int pulses;
      pulses    = 0;
      S_EN      = 1'b1;
      Prescale  = 6'd8;
      Vote_Mode = 2'b01;
      for (int k = 0; k < 4; k++) begin
         edge_count = 6'(k);
         S_Data     = 1'b1;
         @(posedge CLK); #1;
      end
      edge_count = 6'd4;
      if (use_reset) Reset = 1'b0;
      else           S_EN  = 1'b0;
      @(posedge CLK); #1;
      chk(use_reset ? "abort_rst_sampled" : "abort_en_sampled", int'(sampled), 0);
      chk(use_reset ? "abort_rst_bit"     : "abort_en_bit",     int'(Sampled_bit), 0);
      chk(use_reset ? "abort_rst_noise"   : "abort_en_noise",   int'(Noise_err), 0);
      for (int k = 5; k < 8; k++) begin
         edge_count = 6'(k);
         @(posedge CLK); #1;
         if (sampled) pulses++;
      end
      chk(use_reset ? "abort_rst_pulses" : "abort_en_pulses", pulses, 0);
      Reset = 1'b1;
      S_EN  = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{8,  2'b01, 64'h38,  64'h0,  6,  1, 0, 0};
      vecs[1]  = '{8,  2'b01, 64'h28,  64'h0,  6,  1, 1, 0};
      vecs[2]  = '{8,  2'b01, 64'h10,  64'h0,  6,  0, 1, 0};
      vecs[3]  = '{16, 2'b10, 64'h300, 64'h0,  11, 0, 1, 0};
      vecs[4]  = '{4,  2'b10, 64'h4,   64'h0,  3,  1, 0, 1};
      vecs[5]  = '{8,  2'b00, 64'hEF,  64'h0,  5,  0, 0, 0};
      vecs[6]  = '{8,  2'b10, 64'h2C,  64'h0,  7,  1, 1, 0};
      vecs[7]  = '{8,  2'b11, 64'h0,   64'h0,  6,  0, 0, 0};
      vecs[8]  = '{6,  2'b10, 64'h0C,  64'h0,  5,  1, 1, 1};
      vecs[9]  = '{63, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 34, 1, 0, 0};
      vecs[10] = '{5,  2'b01, 64'h11,  64'h0,  4,  0, 0, 0};
      vecs[11] = '{8,  2'b01, 64'h0,   64'h38, 6,  0, 1, 0};
      vecs[12] = '{8,  2'b01, 64'h28,  64'h10, 6,  1, 0, 0};

      Reset      = 1'b0;
      S_EN       = 1'b0;
      S_Data     = 1'b1;
      Prescale   = 6'd8;
      edge_count = 6'd0;
      Vote_Mode  = 2'b01;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_sampled", int'(sampled), 0);
      chk("reset_bit",     int'(Sampled_bit), 0);
      chk("reset_noise",   int'(Noise_err), 0);
      chk("reset_cfg",     int'(Cfg_err), 0);
      Reset = 1'b1;
      @(posedge CLK); #1;

      foreach (vecs[i]) begin
         run_bit(vecs[i].p, vecs[i].mode, 99, vecs[i].mode, vecs[i].data, vecs[i].skip);
         chk($sformatf("vec%0d_pulses", i), n_pulse, 1);
         chk($sformatf("vec%0d_pos", i), pulse_pos, vecs[i].exp_pos);
         chk($sformatf("vec%0d_bit", i), got_bit, vecs[i].exp_bit);
         chk($sformatf("vec%0d_noise", i), got_noise, vecs[i].exp_noise);
         chk($sformatf("vec%0d_cfg", i), got_cfg, vecs[i].exp_cfg);
      end

      // Reset and enable drop mid-window, each preceded by a bit leaving bit=1, noise=1.
      run_bit(8, 2'b01, 99, 2'b01, 64'h28, 64'h0);
      chk("pre_rst_bit", got_bit, 1);
      abort_bit(1'b1);
      run_bit(8, 2'b01, 99, 2'b01, 64'h28, 64'h0);
      chk("pre_en_noise", got_noise, 1);
      abort_bit(1'b0);
      run_bit(8, 2'b01, 99, 2'b01, 64'h38, 64'h0);
      chk("recover_pulses", n_pulse, 1);
      chk("recover_pos", pulse_pos, 6);
      chk("recover_bit", got_bit, 1);

      // Mode change at edge 5 applies only from the next bit.
      run_bit(16, 2'b01, 5, 2'b10, 64'h640, 64'h0);
      chk("mswitch_cur_pulses", n_pulse, 1);
      chk("mswitch_cur_pos", pulse_pos, 10);
      chk("mswitch_cur_bit", got_bit, 0);
      chk("mswitch_cur_noise", got_noise, 1);
      run_bit(16, 2'b10, 99, 2'b10, 64'h640, 64'h0);
      chk("mswitch_next_pos", pulse_pos, 11);
      chk("mswitch_next_bit", got_bit, 1);
      chk("mswitch_next_noise", got_noise, 1);

      // Prescale 4 cannot fit any multi-sample window, so Cfg_err persists while disabled.
      run_bit(4, 2'b10, 99, 2'b10, 64'h4, 64'h0);
      chk("p4_bit", got_bit, 1);
      S_EN = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("dis_cfg", int'(Cfg_err), 1);
      chk("dis_bit", int'(Sampled_bit), 0);
      chk("dis_sampled", int'(sampled), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
